// File: rtl/vexriscv_mem_arbiter_if.sv
// Purpose: one req/gnt/rvalid memory channel (request fields + response).
// Latency: none, wires only.
// Backpressure: requester holds req and fields until gnt; responses are not backpressured.
interface vexriscv_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  req;
  logic                  gnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] strb;
  logic                  we;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  // Issues requests, consumes grants and responses.
  modport master (
    output req, addr, wdata, strb, we,
    input  gnt, rvalid, rdata
  );

  // Accepts requests, produces grants and responses.
  modport slave (
    input  req, addr, wdata, strb, we,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/vexriscv_mem_arbiter.sv
// Purpose: round-robin share of one memory port between instr and data channels, in-order response routing.
// Latency: 0 cycles request->memory and response->requester (combinational in both directions).
// Backpressure: grants follow mem gnt; no request is issued while the routing ID FIFO is full.
module vexriscv_mem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  vexriscv_mem_arbiter_if.slave    instr,
  vexriscv_mem_arbiter_if.slave    data,
  vexriscv_mem_arbiter_if.master   mem,
  output logic                     err_o
);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam logic ID_INSTR = 1'b0;
  localparam logic ID_DATA  = 1'b1;

  // Routing FIFO: one bit per accepted request naming the channel that owns the response.
  logic             id_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             fifo_full;
  logic             fifo_empty;

  logic last_grant;
  logic sel;
  logic handshake;
  logic push;
  logic pop;
  logic stray;

  assign fifo_full  = (count == (PTR_W+1)'(MAX_OUTSTANDING));
  assign fifo_empty = (count == '0);

  // Pick the requester: sole requester wins, a tie goes to whoever did not win last.
  always_comb begin
    sel = ID_INSTR;
    if (instr.req && data.req) begin
      sel = (last_grant == ID_DATA) ? ID_INSTR : ID_DATA;
    end else if (data.req) begin
      sel = ID_DATA;
    end
  end

  // Request mux. Fullness only looks at the registered count so a same-cycle
  // pop never feeds back into req. Requests are held off during reset because
  // a handshake there could not be recorded.
  always_comb begin
    mem.req   = (instr.req | data.req) & ~fifo_full & rst_ni;
    mem.addr  = instr.addr;
    mem.wdata = instr.wdata;
    mem.strb  = instr.strb;
    mem.we    = instr.we;
    if (sel == ID_DATA) begin
      mem.addr  = data.addr;
      mem.wdata = data.wdata;
      mem.strb  = data.strb;
      mem.we    = data.we;
    end
  end

  assign handshake = mem.req & mem.gnt;
  assign push      = handshake;
  assign pop       = mem.rvalid & ~fifo_empty;
  assign stray     = mem.rvalid & fifo_empty;

  // Grant and response steering; rdata is broadcast, only rvalid is routed.
  always_comb begin
    instr.gnt    = handshake & (sel == ID_INSTR);
    data.gnt     = handshake & (sel == ID_DATA);
    instr.rvalid = pop & (id_mem[rd_ptr] == ID_INSTR);
    data.rvalid  = pop & (id_mem[rd_ptr] == ID_DATA);
  end

  assign instr.rdata = mem.rdata;
  assign data.rdata  = mem.rdata;

  // FIFO pointers, occupancy and round-robin history.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_grant <= ID_DATA;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + PTR_W'(1);
        last_grant <= sel;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  // ID storage needs no reset: entries are only read behind a non-zero count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      id_mem[wr_ptr] <= sel;
    end
  end

  // Sticky flag for a response arriving with nothing outstanding.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_o <= 1'b0;
    end else if (stray) begin
      err_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_vexriscv_mem_arbiter.sv
// Purpose: randomized check of vexriscv_mem_arbiter against a queue-based reference model.
// Latency: responses and grants are checked in the same cycle they are driven.
// Backpressure: random mem gnt and sparse responses drive the ID FIFO to full.
module tb_vexriscv_mem_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int SW  = DW / 8;
  localparam int MAX = 4;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic err_o;

  vexriscv_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ibus ();
  vexriscv_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dbus ();
  vexriscv_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mbus ();

  vexriscv_mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAX)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .instr  (ibus),
    .data   (dbus),
    .mem    (mbus),
    .err_o  (err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: outstanding owners in issue order, who won last, sticky error.
  int q[$];
  int last_win = 1;
  bit err_exp = 1'b0;
  bit i_done = 1'b1;
  bit d_done = 1'b1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic new_instr();
    ibus.req   = ($urandom_range(0, 99) < 65);
    ibus.addr  = $urandom;
    ibus.wdata = {$urandom, $urandom};
    ibus.strb  = SW'($urandom);
    ibus.we    = 1'($urandom_range(0, 1));
  endtask

  task automatic new_data();
    dbus.req   = ($urandom_range(0, 99) < 65);
    dbus.addr  = $urandom;
    dbus.wdata = {$urandom, $urandom};
    dbus.strb  = SW'($urandom);
    dbus.we    = 1'($urandom_range(0, 1));
  endtask

  // One clock: drive after the edge, check on the falling edge, advance the model.
  task automatic run_cycle(input int p_gnt, input int p_rv, input int p_stray);
    bit full, e_req, hs, pop, stray, e_ig, e_dg, e_irv, e_drv;
    int sel;
    @(posedge clk_i);
    #1;
    // Requesters keep req and fields stable until granted.
    if (!ibus.req || i_done) new_instr();
    if (!dbus.req || d_done) new_data();
    mbus.gnt   = ($urandom_range(0, 99) < p_gnt);
    mbus.rdata = {$urandom, $urandom};
    if (q.size() > 0) mbus.rvalid = ($urandom_range(0, 99) < p_rv);
    else              mbus.rvalid = ($urandom_range(0, 99) < p_stray);

    @(negedge clk_i);
    full  = (q.size() == MAX);
    e_req = (ibus.req || dbus.req) && !full;
    if (ibus.req && dbus.req) sel = (last_win == 1) ? 0 : 1;
    else                      sel = dbus.req ? 1 : 0;
    hs    = e_req && mbus.gnt;
    e_ig  = hs && (sel == 0);
    e_dg  = hs && (sel == 1);
    pop   = mbus.rvalid && (q.size() > 0);
    stray = mbus.rvalid && (q.size() == 0);
    e_irv = pop && (q[0] == 0);
    e_drv = pop && (q[0] == 1);

    chk("mem_req",      64'(mbus.req),     64'(e_req));
    chk("instr_gnt",    64'(ibus.gnt),     64'(e_ig));
    chk("data_gnt",     64'(dbus.gnt),     64'(e_dg));
    chk("mem_addr",     64'(mbus.addr),    64'(sel ? dbus.addr  : ibus.addr));
    chk("mem_wdata",    mbus.wdata,        sel ? dbus.wdata : ibus.wdata);
    chk("mem_strb",     64'(mbus.strb),    64'(sel ? dbus.strb  : ibus.strb));
    chk("mem_we",       64'(mbus.we),      64'(sel ? dbus.we    : ibus.we));
    chk("instr_rvalid", 64'(ibus.rvalid),  64'(e_irv));
    chk("data_rvalid",  64'(dbus.rvalid),  64'(e_drv));
    chk("instr_rdata",  ibus.rdata,        mbus.rdata);
    chk("data_rdata",   dbus.rdata,        mbus.rdata);
    chk("err",          64'(err_o),        64'(err_exp));

    if (pop) void'(q.pop_front());
    if (hs) begin
      q.push_back(sel);
      last_win = sel;
    end
    if (stray) err_exp = 1'b1;
    i_done = e_ig;
    d_done = e_dg;
  endtask

  task automatic zero_inputs();
    ibus.req = 1'b0; ibus.addr = '0; ibus.wdata = '0; ibus.strb = '0; ibus.we = 1'b0;
    dbus.req = 1'b0; dbus.addr = '0; dbus.wdata = '0; dbus.strb = '0; dbus.we = 1'b0;
    mbus.gnt = 1'b0; mbus.rvalid = 1'b0; mbus.rdata = '0;
  endtask

  // Reset with everything active on the inputs: grants and responses must stay quiet.
  task automatic reset_check(input string tag);
    ibus.req = 1'b1; dbus.req = 1'b1; mbus.gnt = 1'b1; mbus.rvalid = 1'b1;
    rst_ni = 1'b0;
    #1;
    chk({tag, "_instr_gnt"},    64'(ibus.gnt),    64'd0);
    chk({tag, "_data_gnt"},     64'(dbus.gnt),    64'd0);
    chk({tag, "_instr_rvalid"}, 64'(ibus.rvalid), 64'd0);
    chk({tag, "_data_rvalid"},  64'(dbus.rvalid), 64'd0);
    chk({tag, "_err"},          64'(err_o),       64'd0);
    q.delete();
    last_win = 1;
    err_exp  = 1'b0;
    i_done   = 1'b1;
    d_done   = 1'b1;
    @(negedge clk_i);
    zero_inputs();
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    zero_inputs();
    #2;
    reset_check("reset");

    // Tie-break after reset: first simultaneous request goes to instr.
    for (int i = 0; i < 300; i++) run_cycle(80, 70, 0);
    // Sparse responses keep the FIFO at its limit.
    for (int i = 0; i < 300; i++) run_cycle(90, 10, 0);
    // Reset with outstanding requests pending.
    @(posedge clk_i);
    #1;
    reset_check("midrst");
    for (int i = 0; i < 300; i++) run_cycle(60, 50, 0);
    // Stray responses raise the sticky error.
    for (int i = 0; i < 200; i++) run_cycle(50, 40, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vexriscv_mem_arbiter.md
Name: vexriscv_mem_arbiter

Overview:
Shares one single-port 64-bit memory between the core's instruction and data request channels, using a req/gnt/rvalid protocol.
- Arbitrates round-robin per accepted request.
- Tracks outstanding transactions in an in-order ID FIFO and routes each response back to the requester that issued it.
- Sits between the core wrapper and the shared memory in the tiny SoC.

Parameters:
ADDR_WIDTH, 32, request address width
DATA_WIDTH, 64, data width; STRB_WIDTH = DATA_WIDTH/8
MAX_OUTSTANDING, 4, depth of the response-routing ID FIFO (power of two, 2..16)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
instr_req_i  in  1  instruction request; held until granted
instr_gnt_o  out  1  instruction request accepted this cycle
instr_addr_i  in  ADDR_WIDTH  instruction address
instr_wdata_i  in  DATA_WIDTH  instruction write data
instr_strb_i  in  STRB_WIDTH  instruction byte strobes
instr_we_i  in  1  instruction write enable
instr_rvalid_o  out  1  instruction response valid
instr_rdata_o  out  DATA_WIDTH  instruction response data
data_req_i, data_gnt_o, data_addr_i, data_wdata_i, data_strb_i, data_we_i, data_rvalid_o, data_rdata_o: same as instr_*
mem_req_o  out  1  request to shared memory
mem_gnt_i  in  1  memory accepts request
mem_addr_o  out  ADDR_WIDTH  muxed address
mem_wdata_o  out  DATA_WIDTH  muxed write data
mem_strb_o  out  STRB_WIDTH  muxed strobes
mem_we_o  out  1  muxed write enable
mem_rvalid_i  in  1  memory response (one per accepted request, reads and writes, in order)
mem_rdata_i  in  DATA_WIDTH  memory response data
err_o  out  1  sticky protocol error

Behaviour:
- Reset (async, rst_ni=0): ID FIFO empty, last_grant=DATA, err_o=0. All gnt/rvalid outputs read 0 while in reset.
- Clock and reset are the only sequencing inputs; no enable or flush.
- Selection (combinational):
  - Only one channel requesting: select it.
  - Both requesting: select the channel != last_grant.
  - The first tie after reset goes to INSTR.
- Request path:
  - mem_req_o = (instr_req_i | data_req_i) & ~fifo_full.
  - mem_addr/wdata/strb/we_o = fields of the selected channel; when the data channel is unselected, drive instr fields.
- Grant:
  - Selected channel's gnt_o = mem_gnt_i & mem_req_o. Unselected channel's gnt_o = 0.
  - Zero-cycle combinational path mem_gnt_i -> *_gnt_o.
- Handshake (mem_req_o & mem_gnt_i):
  - Push the selected ID (0=INSTR, 1=DATA) into the FIFO.
  - last_grant <= selected ID.
  - last_grant changes only on a handshake, not on request alone.
- Response: on mem_rvalid_i with FIFO non-empty:
  - Pop the head.
  - Assert the matching *_rvalid_o for the same cycle (combinational).
  - Both *_rdata_o = mem_rdata_i unconditionally; only rvalid is steered.
- Response latency: arbiter adds 0 cycles in each direction. Throughput is 1 transaction/cycle when the FIFO is not full.
- FIFO full (count==MAX_OUTSTANDING):
  - mem_req_o=0 and no grants, even if mem_rvalid_i pops in the same cycle. This is intentional; it avoids a rvalid->req path.
  - Requests resume the cycle after count drops.
- Simultaneous push and pop (not full): count unchanged, pointers both advance. Wrap-around via ADDR bits log2(MAX_OUTSTANDING), with a separate count register.
- Stray response (mem_rvalid_i while FIFO empty): no rvalid output, set err_o=1 (sticky until reset).
- Requester drops req before gnt: protocol violation, not detected. Arbitration simply re-evaluates each cycle.
- Reset mid-operation: outstanding IDs are discarded. Responses arriving after reset deassertion with an empty FIFO set err_o.

Test Plan:
1. Only instr_req_i=1, addr=0x80, mem_gnt_i=1, mem_rvalid_i one cycle later with rdata=0xDEADBEEF_00000013 -> instr_gnt_o=1 same cycle, mem_addr_o=0x80, instr_rvalid_o=1 with that data, data_rvalid_o=0.
2. Both requesting continuously, mem_gnt_i=1, responses returned each next cycle -> grants alternate I,D,I,D starting with INSTR; rvalid steering matches grant order.
3. mem_gnt_i=1 for 4 cycles with instr requests, no responses (MAX_OUTSTANDING=4) -> 4 grants, then mem_req_o=0. Assert mem_rvalid_i once -> mem_req_o stays 0 that cycle, returns to 1 the next.
4. Data write (we=1, strb=0x0F, addr=0x10, wdata=0x5) interleaved with instr read, memory latency 3 -> mem_we_o/mem_strb_o follow the selected channel. Responses route in order: INSTR then DATA.
5. mem_rvalid_i=1 with no outstanding requests -> no *_rvalid_o, err_o rises and stays 1 until rst_ni=0.
6. Assert rst_ni=0 with 2 outstanding -> gnt/rvalid=0 immediately, FIFO empty. After release, a new request is granted normally and last_grant=DATA, so INSTR wins the next tie.
